// File: rtl/wheel_pedal_emu.sv
// Steering wheel / gas pedal emulator for the multiplexed analog port.
// Digital directions are integrated once per frame into steering and gas
// bytes; analog stick and paddle are mapped combinationally onto the same
// byte, and the core's select bit picks steering or gas.
module wheel_pedal_emu #(
  parameter logic [7:0]  STEER_CENTER = 8'h70,
  parameter logic [7:0]  STEER_MIN    = 8'h30,
  parameter logic [7:0]  STEER_MAX    = 8'hB0,
  parameter int unsigned VMAX         = 4,
  parameter int unsigned RETURN_STEP  = 2,
  parameter int unsigned GAS_STEP     = 4,
  parameter int unsigned GAS_DECAY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       steer_plus,
  input  logic       steer_minus,
  input  logic       gas_plus,
  input  logic       gas_minus,
  input  logic [1:0] steer_mode,
  input  logic       gas_analog,
  input  logic       gas_allow_pos,
  input  logic [7:0] joy_x,
  input  logic [7:0] joy_y,
  input  logic [7:0] paddle,
  input  logic       sel_steer,
  output logic [7:0] data_out,
  output logic [7:0] steer_emu,
  output logic [7:0] gas_emu
);

  typedef enum logic [1:0] {IDLE, RIGHT, LEFT} steer_state_t;

  localparam logic [3:0]        VMAX_V    = 4'(VMAX);
  localparam logic [7:0]        GAS_DEC_V = 8'(GAS_DECAY);
  localparam logic [8:0]        GAS_INC_V = 9'(GAS_STEP);
  localparam logic signed [8:0] S_CTR     = $signed({1'b0, STEER_CENTER});
  localparam logic signed [8:0] S_MIN     = $signed({1'b0, STEER_MIN});
  localparam logic signed [8:0] S_MAX     = $signed({1'b0, STEER_MAX});
  localparam logic signed [8:0] S_RET     = $signed(9'(RETURN_STEP));

  steer_state_t      state, state_nxt;
  logic              vsync_d;
  logic              tick;
  logic [3:0]        vel, vel_nxt;
  logic [7:0]        steer_nxt, gas_nxt, dout_nxt;
  logic signed [8:0] s_cur, s_calc;
  logic [8:0]        g_up;
  logic [7:0]        steer_x, steer_p, gas_a;
  logic [6:0]        graw;

  assign tick = vsync & ~vsync_d;

  // Frame strobe edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vsync_d <= 1'b0;
    else       vsync_d <= vsync;
  end

  // Emulator state: direction, velocity, steering and gas advance on tick only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      vel       <= '0;
      steer_emu <= STEER_CENTER;
      gas_emu   <= '0;
    end else if (tick) begin
      state     <= state_nxt;
      vel       <= vel_nxt;
      steer_emu <= steer_nxt;
      gas_emu   <= gas_nxt;
    end
  end

  // Steering next-state: ramped velocity while held, self-centring when idle
  always_comb begin
    state_nxt = IDLE;
    vel_nxt   = '0;
    s_cur     = $signed({1'b0, steer_emu});
    s_calc    = s_cur;
    if (steer_plus && !steer_minus) begin
      state_nxt = RIGHT;
      vel_nxt   = (state != RIGHT) ? 4'd1 : ((vel >= VMAX_V) ? VMAX_V : vel + 4'd1);
      s_calc    = s_cur + $signed({5'b0, vel_nxt});
      if (s_calc > S_MAX) s_calc = S_MAX;
    end else if (steer_minus && !steer_plus) begin
      state_nxt = LEFT;
      vel_nxt   = (state != LEFT) ? 4'd1 : ((vel >= VMAX_V) ? VMAX_V : vel + 4'd1);
      s_calc    = s_cur - $signed({5'b0, vel_nxt});
      if (s_calc < S_MIN) s_calc = S_MIN;
    end else begin
      if (s_cur > S_CTR + S_RET)      s_calc = s_cur - S_RET;
      else if (s_cur < S_CTR - S_RET) s_calc = s_cur + S_RET;
      else                            s_calc = S_CTR;
    end
    steer_nxt = s_calc[7:0];
  end

  // Gas next value: saturating rise, floored decay, hold when both pressed
  always_comb begin
    g_up    = {1'b0, gas_emu} + GAS_INC_V;
    gas_nxt = gas_emu;
    if (gas_plus && !gas_minus)
      gas_nxt = g_up[8] ? 8'hFF : g_up[7:0];
    else if (!(gas_plus && gas_minus))
      gas_nxt = (gas_emu < GAS_DEC_V) ? '0 : gas_emu - GAS_DEC_V;
  end

  // Analog mappings; only the low 7 bits of the Y magnitude reach the output,
  // and those bits of a two's-complement negation depend only on joy_y[6:0]
  always_comb begin
    steer_x = STEER_CENTER + {joy_x[7], joy_x[7:1]};
    steer_p = STEER_CENTER + {~paddle[7], ~paddle[7], paddle[6:1]};
    graw    = joy_y[7] ? (7'h00 - joy_y[6:0]) : (gas_allow_pos ? joy_y[6:0] : 7'h00);
    gas_a   = {graw, 1'b1};
    if (sel_steer) begin
      case (steer_mode)
        2'd0:    dout_nxt = steer_emu;
        2'd1:    dout_nxt = steer_x;
        default: dout_nxt = steer_p;
      endcase
    end else begin
      dout_nxt = gas_analog ? gas_a : gas_emu;
    end
  end

  // Registered port byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_out <= '0;
    else       data_out <= dout_nxt;
  end

endmodule

// File: tb/tb_wheel_pedal_emu.sv
// Self-checking bench for wheel_pedal_emu: directed plan sequences, a table
// of analog-mapping vectors and randomized frames against an abstract model.
`timescale 1ns/1ps
module tb_wheel_pedal_emu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       steer_plus = 1'b0, steer_minus = 1'b0;
  logic       gas_plus = 1'b0, gas_minus = 1'b0;
  logic [1:0] steer_mode = 2'd0;
  logic       gas_analog = 1'b0, gas_allow_pos = 1'b0;
  logic [7:0] joy_x = 8'h00, joy_y = 8'h00, paddle = 8'h80;
  logic       sel_steer = 1'b1;
  logic [7:0] data_out, steer_emu, gas_emu;

  int n_cmp = 0;
  int n_bad = 0;

  // Abstract model: positions as integers, direction -1/0/+1
  int m_steer, m_vel, m_dir, m_gas;

  typedef struct {
    logic [1:0] mode;
    logic       sel;
    logic       ga;
    logic       allow;
    logic [7:0] jx, jy, pd, exp;
  } vec_t;
  vec_t vecs [14];

  always #12.5 clk = ~clk;

  wheel_pedal_emu dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .steer_plus(steer_plus), .steer_minus(steer_minus),
    .gas_plus(gas_plus), .gas_minus(gas_minus),
    .steer_mode(steer_mode), .gas_analog(gas_analog), .gas_allow_pos(gas_allow_pos),
    .joy_x(joy_x), .joy_y(joy_y), .paddle(paddle), .sel_steer(sel_steer),
    .data_out(data_out), .steer_emu(steer_emu), .gas_emu(gas_emu)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h want 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_steer = 112; m_vel = 0; m_dir = 0; m_gas = 0;
  endtask

  task automatic model_tick();
    int d;
    d = (steer_plus && !steer_minus) ? 1 : ((steer_minus && !steer_plus) ? -1 : 0);
    if (d != 0) begin
      m_vel = (d == m_dir) ? ((m_vel + 1 > 4) ? 4 : m_vel + 1) : 1;
      m_steer = m_steer + d * m_vel;
      if (m_steer > 176) m_steer = 176;
      if (m_steer < 48)  m_steer = 48;
    end else begin
      m_vel = 0;
      if (m_steer > 114)      m_steer = m_steer - 2;
      else if (m_steer < 110) m_steer = m_steer + 2;
      else                    m_steer = 112;
    end
    m_dir = d;
    if (gas_plus && !gas_minus) m_gas = (m_gas + 4 > 255) ? 255 : m_gas + 4;
    else if (!(gas_plus && gas_minus)) m_gas = (m_gas - 2 < 0) ? 0 : m_gas - 2;
  endtask

  function automatic logic [7:0] exp_dout();
    int v, j;
    if (sel_steer) begin
      if (steer_mode == 2'd0) v = m_steer;
      else if (steer_mode == 2'd1) begin
        j = int'($signed(joy_x));
        v = 112 + (j >>> 1);
      end else begin
        j = int'(paddle) - 128;
        v = 112 + (j >>> 1);
      end
    end else if (gas_analog) begin
      j = int'($signed(joy_y));
      j = (j < 0) ? -j : (gas_allow_pos ? j : 0);
      v = 2 * j + 1;
    end else begin
      v = m_gas;
    end
    return 8'(v & 255);
  endfunction

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
  endtask

  // One frame: vsync high two cycles, low two cycles, then compare to model
  task automatic do_tick();
    @(negedge clk); vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    model_tick();
    check("steer_model", steer_emu, 8'(m_steer));
    check("gas_model", gas_emu, 8'(m_gas));
    check("dout_model", data_out, exp_dout());
  endtask

  initial begin
    logic [7:0] ramp_exp [7];
    ramp_exp = '{8'h71, 8'h73, 8'h76, 8'h74, 8'h72, 8'h70, 8'h70};
    vecs[0]  = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h00, 8'h80, 8'h30};
    vecs[1]  = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h00, 8'h80, 8'hAF};
    vecs[2]  = '{2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h80, 8'h70};
    vecs[3]  = '{2'd1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h80, 8'h6F};
    vecs[4]  = '{2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h30};
    vecs[5]  = '{2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h80, 8'h70};
    vecs[6]  = '{2'd2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 8'hAF};
    vecs[7]  = '{2'd3, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h30};
    vecs[8]  = '{2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hC0, 8'h80, 8'h81};
    vecs[9]  = '{2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 8'h80, 8'h01};
    vecs[10] = '{2'd0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h40, 8'h80, 8'h81};
    vecs[11] = '{2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 8'h80, 8'h01};
    vecs[12] = '{2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h80, 8'h03};
    vecs[13] = '{2'd0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h7F, 8'h80, 8'hFF};

    // Reset values
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_steer", steer_emu, 8'h70);
    check("rst_gas", gas_emu, 8'h00);
    check("rst_dout", data_out, 8'h00);
    @(negedge clk); reset = 1'b0;

    // Right ramp then self-centring
    steer_mode = 2'd0; sel_steer = 1'b1; steer_plus = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) steer_plus = 1'b0;
      do_tick();
      check("ramp_dout", data_out, ramp_exp[i]);
    end

    // Left clamp, then both pressed
    steer_minus = 1'b1;
    for (int i = 0; i < 40; i++) do_tick();
    check("left_clamp", steer_emu, 8'h30);
    check("left_clamp_dout", data_out, 8'h30);
    steer_plus = 1'b1;
    do_tick();
    check("both_center", steer_emu, 8'h32);
    steer_plus = 1'b0; steer_minus = 1'b0;

    // Gas saturation and decay to floor
    sel_steer = 1'b0; gas_plus = 1'b1;
    for (int i = 0; i < 70; i++) do_tick();
    check("gas_sat", data_out, 8'hFF);
    gas_plus = 1'b0;
    for (int i = 0; i < 126; i++) do_tick();
    check("gas_03", gas_emu, 8'h03);
    do_tick(); check("gas_decay1", data_out, 8'h01);
    do_tick(); check("gas_decay2", data_out, 8'h00);
    do_tick(); check("gas_floor", data_out, 8'h00);

    // Analog mapping table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      steer_mode = vecs[i].mode; sel_steer = vecs[i].sel;
      gas_analog = vecs[i].ga;   gas_allow_pos = vecs[i].allow;
      joy_x = vecs[i].jx; joy_y = vecs[i].jy; paddle = vecs[i].pd;
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d", i), data_out, vecs[i].exp);
    end
    steer_mode = 2'd0; sel_steer = 1'b1; gas_analog = 1'b0; gas_allow_pos = 1'b0;

    // Long vsync: exactly one tick
    do_reset();
    steer_plus = 1'b1;
    @(negedge clk); vsync = 1'b1;
    repeat (1000) @(negedge clk);
    check("long_vsync_hi", steer_emu, 8'h71);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    model_tick();
    check("long_vsync_lo", steer_emu, 8'h71);
    check("long_vsync_dout", data_out, 8'h71);

    // Async reset mid-ramp, between edges
    gas_plus = 1'b1;
    do_tick(); do_tick();
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_steer", steer_emu, 8'h70);
    check("arst_gas", gas_emu, 8'h00);
    check("arst_dout", data_out, 8'h00);
    @(negedge clk); reset = 1'b0;
    model_reset();
    do_tick();
    check("arst_fresh", steer_emu, 8'h71);
    gas_plus = 1'b0;

    // Randomized frames against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        steer_plus  = 1'($urandom_range(0, 1));
        steer_minus = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        gas_plus  = 1'($urandom_range(0, 1));
        gas_minus = 1'($urandom_range(0, 1));
      end
      steer_mode    = 2'($urandom_range(0, 3));
      sel_steer     = 1'($urandom_range(0, 1));
      gas_analog    = 1'($urandom_range(0, 1));
      gas_allow_pos = 1'($urandom_range(0, 1));
      joy_x  = 8'($urandom);
      joy_y  = 8'($urandom);
      paddle = 8'($urandom);
      do_tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wheel_pedal_emu.md
Name: wheel_pedal_emu

Overview:
- Upstream input stage for the driving games (Spy Hunter, Turbo Tag); produces the 8-bit byte on the core's multiplexed analog port, input_2.
- Emulates a steering wheel and a gas pedal from digital joystick directions, stepping once per video frame.
- Also maps an analog stick or a paddle onto the same byte.
- The core's mux-select output bit picks which quantity, steering or gas, appears on the port.

Parameters:
STEER_CENTER 8'h70 steering rest value
STEER_MIN 8'h30 lower clamp for emulated steering
STEER_MAX 8'hB0 upper clamp for emulated steering
VMAX 4 maximum steering velocity, in counts per tick
RETURN_STEP 2 self-centring step per tick
GAS_STEP 4 gas increase per tick
GAS_DECAY 2 gas decrease per tick (pedal released or gas_minus)

Ports:
clk in 1 system clock (40 MHz)
reset in 1 asynchronous, active-high reset
vsync in 1 frame strobe; its rising edge is the update tick
steer_plus in 1 digital right
steer_minus in 1 digital left
gas_plus in 1 digital accelerate
gas_minus in 1 digital brake
steer_mode in 2 0=digital, 1=analog X, 2=paddle, 3=treated as 2
gas_analog in 1 1=gas taken from analog Y
gas_allow_pos in 1 1=positive analog Y also counts as gas
joy_x in 8 signed analog X
joy_y in 8 signed analog Y
paddle in 8 unsigned paddle position
sel_steer in 1 core mux select: 1=steering byte, 0=gas byte
data_out out 8 registered byte to the core
steer_emu out 8 current emulated steering value
gas_emu out 8 current emulated gas value

Behaviour:
- Reset (asynchronous, active-high):
  - steer_emu=STEER_CENTER, gas_emu=8'h00, data_out=8'h00.
  - Velocity register=0; vsync edge register=0.
  - Reset mid-operation discards all emulator state immediately.
- Tick:
  - tick = vsync & ~vsync_d, where vsync_d is registered on clk.
  - Exactly one tick per rising edge, however long vsync stays high.
  - Emulator state changes only on tick cycles.
- Steering state machine, states IDLE, RIGHT, LEFT, evaluated on each tick:
  - steer_plus & ~steer_minus -> RIGHT.
    - Entering RIGHT from another state sets vel=1.
    - Staying in RIGHT sets vel=min(vel+1,VMAX).
    - steer_emu = min(steer_emu+vel, STEER_MAX).
  - steer_minus & ~steer_plus -> LEFT; mirror of RIGHT, with the result clamped at STEER_MIN.
  - Neither or both pressed -> IDLE, vel=0.
    - steer_emu moves toward STEER_CENTER by RETURN_STEP.
    - It lands exactly on STEER_CENTER if within RETURN_STEP; it never overshoots.
  - Intermediate arithmetic is 9-bit signed; clamping happens before the 8-bit store.
- Gas, evaluated on each tick:
  - gas_plus & ~gas_minus: gas_emu = min(gas_emu+GAS_STEP, 8'hFF).
  - gas_minus & ~gas_plus, or neither pressed: gas_emu = max(gas_emu-GAS_DECAY, 0).
  - Both pressed: hold.
- Analog mapping (combinational; all sums wrap modulo 256):
  - steerX = STEER_CENTER + {joy_x[7], joy_x[7:1]}.
  - steerP = STEER_CENTER + {~paddle[7], ~paddle[7], paddle[6:1]}.
  - graw = joy_y[7] ? (8'h00 - joy_y) : (gas_allow_pos ? joy_y : 8'h00).
  - gasA = {graw[6:0], 1'b1}.
- Output mux: data_out registered every clk, giving 1-cycle latency from any input change.
  - sel_steer=1: the steering source chosen by steer_mode (steer_emu / steerX / steerP).
  - sel_steer=0: gas_analog ? gasA : gas_emu.
- The emulators keep running while analog modes are selected. A mode switch makes no reload; switching back to digital resumes from the current emulator state.
- Simultaneous tick and mode or select change: the emulator updates normally, and data_out reflects the new select one cycle later.

Test Plan:
- Reset, then steer_plus held for 3 ticks, steer_mode=0, sel_steer=1 -> data_out 0x71, 0x73, 0x76. Release -> 0x74, 0x72, 0x70, 0x70.
- steer_minus held for 40 ticks -> steer_emu clamps at 0x30 and stays. Pressing both on the next tick -> vel=0, steer_emu 0x32.
- gas_plus held for 70 ticks, sel_steer=0 -> data_out saturates at 0xFF. From gas_emu=0x03 with pedal released -> 0x01, 0x00, 0x00.
- Analog mappings:
  - joy_x=0x80, steer_mode=1 -> data_out 0x30.
  - paddle=0x00, steer_mode=2 -> 0x30.
  - joy_y=0xC0, gas_analog=1, sel_steer=0 -> 0x81.
  - joy_y=0x40 with gas_allow_pos=0 -> 0x01; with gas_allow_pos=1 -> 0x81.
- vsync held high for 1000 cycles with steer_plus -> exactly one tick, steer_emu 0x71.
- Async reset asserted mid-ramp, between clk edges -> outputs go to 0x70 / 0x00 / 0x00 without waiting for a clk edge. The first tick after release starts a fresh ramp at vel=1.
